// File: rtl/mod_sram_ctrl_if.sv
// Host + SRAM-side bus bundle for mod_sram_ctrl.
// slave  : the controller (drives SRAM pins, rdata/busy/done)
// master : host / SRAM model side
interface mod_sram_ctrl_if;
  // host side
  logic        req;
  logic        wr;
  logic [14:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        busy;
  logic        done;
  // SRAM side
  logic [14:0] a;
  logic        cs;
  logic        oe;
  logic        we;
  logic [7:0]  io_out;
  logic        io_oe;
  logic [7:0]  io_in;

  modport slave (
    input  req, wr, addr, wdata, io_in,
    output rdata, busy, done, a, cs, oe, we, io_out, io_oe
  );

  modport master (
    output req, wr, addr, wdata, io_in,
    input  rdata, busy, done, a, cs, oe, we, io_out, io_oe
  );
endinterface

// File: rtl/mod_sram_ctrl.sv
// Asynchronous SRAM controller: one access at a time, fixed-length
// CS/OE read window, setup/pulse/hold write, optional bus turnaround
// after reads. Every SRAM pin and host status output comes straight
// from a flop; the next-cycle pin values are decoded from the next state.
module mod_sram_ctrl #(
  parameter int RD_CYC   = 2,
  parameter int WR_CYC   = 2,
  parameter int TURN_CYC = 1
) (
  input logic             clk,
  input logic             rst,
  mod_sram_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, RD_ACT, RD_DONE, TURN, WR_SETUP, WR_PULSE, WR_HOLD, WR_DONE
  } state_t;

  // Counters hold "cycles remaining after this one", so a state lasting
  // N cycles is entered with N-1.
  localparam logic [3:0] RD_LD   = 4'(RD_CYC - 1);
  localparam logic [3:0] WR_LD   = 4'(WR_CYC - 1);
  localparam logic [3:0] TURN_LD = (TURN_CYC > 0) ? 4'(TURN_CYC - 1) : 4'd0;
  localparam bit         HAS_TURN = (TURN_CYC > 0);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [14:0] a_q, a_nx;
  logic [7:0]  io_out_q, io_out_nx;
  logic [7:0]  rdata_q, rdata_nx;
  logic        cs_nx, oe_nx, we_nx, io_oe_nx, busy_nx, done_nx;
  logic        cs_q, oe_q, we_q, io_oe_q, busy_q, done_q;

  // Next state, counter reload on every entry, address/data/read capture.
  always_comb begin
    state_nx  = state;
    cnt_nx    = (cnt != 4'd0) ? cnt - 4'd1 : 4'd0;
    a_nx      = a_q;
    io_out_nx = io_out_q;
    rdata_nx  = rdata_q;
    case (state)
      IDLE: begin
        if (bus.req) begin
          a_nx = bus.addr;
          if (bus.wr) begin
            state_nx  = WR_SETUP;
            io_out_nx = bus.wdata;
            cnt_nx    = 4'd0;
          end else begin
            state_nx = RD_ACT;
            cnt_nx   = RD_LD;
          end
        end
      end
      RD_ACT: begin
        if (cnt == 4'd0) begin
          state_nx = RD_DONE;
          rdata_nx = bus.io_in;
          cnt_nx   = 4'd0;
        end
      end
      RD_DONE: begin
        if (HAS_TURN) begin
          state_nx = TURN;
          cnt_nx   = TURN_LD;
        end else begin
          state_nx = IDLE;
          cnt_nx   = 4'd0;
        end
      end
      TURN: begin
        if (cnt == 4'd0) begin
          state_nx = IDLE;
          cnt_nx   = 4'd0;
        end
      end
      WR_SETUP: begin
        state_nx = WR_PULSE;
        cnt_nx   = WR_LD;
      end
      WR_PULSE: begin
        if (cnt == 4'd0) begin
          state_nx = WR_HOLD;
          cnt_nx   = 4'd0;
        end
      end
      WR_HOLD: begin
        state_nx = WR_DONE;
        cnt_nx   = 4'd0;
      end
      WR_DONE: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // Pin values for the cycle that state_nx will occupy.
  always_comb begin
    cs_nx    = 1'b1;
    oe_nx    = 1'b1;
    we_nx    = 1'b1;
    io_oe_nx = 1'b0;
    busy_nx  = (state_nx != IDLE);
    done_nx  = 1'b0;
    case (state_nx)
      RD_ACT: begin
        cs_nx = 1'b0;
        oe_nx = 1'b0;
      end
      WR_SETUP, WR_HOLD: begin
        cs_nx    = 1'b0;
        io_oe_nx = 1'b1;
      end
      WR_PULSE: begin
        cs_nx    = 1'b0;
        we_nx    = 1'b0;
        io_oe_nx = 1'b1;
      end
      RD_DONE, WR_DONE: done_nx = 1'b1;
      default: ;
    endcase
  end

  // State and registered outputs; reset aborts any access immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      a_q      <= 15'h0000;
      io_out_q <= 8'h00;
      rdata_q  <= 8'h00;
      cs_q     <= 1'b1;
      oe_q     <= 1'b1;
      we_q     <= 1'b1;
      io_oe_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      a_q      <= a_nx;
      io_out_q <= io_out_nx;
      rdata_q  <= rdata_nx;
      cs_q     <= cs_nx;
      oe_q     <= oe_nx;
      we_q     <= we_nx;
      io_oe_q  <= io_oe_nx;
      busy_q   <= busy_nx;
      done_q   <= done_nx;
    end
  end

  assign bus.a      = a_q;
  assign bus.io_out = io_out_q;
  assign bus.rdata  = rdata_q;
  assign bus.cs     = cs_q;
  assign bus.oe     = oe_q;
  assign bus.we     = we_q;
  assign bus.io_oe  = io_oe_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_mod_sram_ctrl.sv
// Directed bench for mod_sram_ctrl: default-parameter instance driven
// cycle by cycle, plus a fast-timing instance run against a reference
// memory. Inputs change and outputs are sampled on the falling edge.
module tb_mod_sram_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_sram_ctrl_if b1 ();
  mod_sram_ctrl_if b2 ();

  mod_sram_ctrl dut1 (.clk(clk), .rst(rst), .bus(b1));
  mod_sram_ctrl #(.RD_CYC(1), .WR_CYC(1), .TURN_CYC(0)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  int checks = 0;
  int errors = 0;

  // SRAM model behind dut2 and the reference contents the host expects.
  logic [7:0] smem    [0:32767];
  logic [7:0] ref_mem [0:32767];
  bit         ref_vld [0:32767];
  assign b2.io_in = smem[b2.a];
  always @(posedge clk) if (b2.cs == 1'b0 && b2.we == 1'b0) smem[b2.a] <= b2.io_out;

  // Pin-protocol invariants on dut1, evaluated every cycle.
  int          inv_viol = 0;
  logic        rst_at_edge = 1'b1;
  logic        p_cs = 1'b1, p_we = 1'b1;
  logic [14:0] p_a = '0;
  logic [7:0]  p_io = '0;
  always @(posedge clk) rst_at_edge <= rst;
  always @(negedge clk) begin
    if (b1.we === 1'b0 && b1.oe === 1'b0) inv_viol++;
    if (b1.io_oe === 1'b1 && b1.oe === 1'b0) inv_viol++;
    if (p_cs === 1'b0 && b1.cs === 1'b0 && (b1.a !== p_a || b1.io_out !== p_io)) inv_viol++;
    if (p_we === 1'b1 && b1.we === 1'b0 && b1.cs !== 1'b0) inv_viol++;
    if (!rst_at_edge && p_cs === 1'b0 && b1.cs === 1'b1 && p_we !== 1'b1) inv_viol++;
    p_cs = b1.cs; p_we = b1.we; p_a = b1.a; p_io = b1.io_out;
  end

  task automatic cyc(); @(negedge clk); endtask

  task automatic test_reset();
    rst = 1'b1;
    b1.req = 0; b1.wr = 0; b1.addr = '0; b1.wdata = '0; b1.io_in = '0;
    b2.req = 0; b2.wr = 0; b2.addr = '0; b2.wdata = '0;
    repeat (3) cyc();
    checks++;
    if ({b1.cs, b1.oe, b1.we, b1.io_oe, b1.busy, b1.done} !== 6'b111000) begin
      errors++; $display("FAIL reset_ctl got %b want 111000", {b1.cs, b1.oe, b1.we, b1.io_oe, b1.busy, b1.done});
    end
    checks++;
    if (b1.rdata !== 8'h00 || b1.a !== 15'h0000 || b1.io_out !== 8'h00) begin
      errors++; $display("FAIL reset_data got rdata=%h a=%h io_out=%h want 0", b1.rdata, b1.a, b1.io_out);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_read();
    logic [5:1] e_cs = 5'b11100, e_done = 5'b00100, e_busy = 5'b01111;
    b1.req = 1; b1.wr = 0; b1.addr = 15'h1234; b1.io_in = 8'hA5;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      b1.req = 0;
      checks++;
      if (b1.cs !== e_cs[c] || b1.oe !== e_cs[c] || b1.we !== 1'b1 || b1.io_oe !== 1'b0) begin
        errors++; $display("FAIL read_pins c%0d got cs=%b oe=%b we=%b io_oe=%b want cs=oe=%b we=1 io_oe=0", c, b1.cs, b1.oe, b1.we, b1.io_oe, e_cs[c]);
      end
      checks++;
      if (b1.done !== e_done[c] || b1.busy !== e_busy[c] || b1.a !== 15'h1234) begin
        errors++; $display("FAIL read_status c%0d got done=%b busy=%b a=%h want %b %b 1234", c, b1.done, b1.busy, b1.a, e_done[c], e_busy[c]);
      end
      if (c >= 3) begin
        checks++;
        if (b1.rdata !== 8'hA5) begin errors++; $display("FAIL read_data c%0d got %h want a5", c, b1.rdata); end
      end
    end
  endtask

  task automatic test_write();
    logic [6:1] e_ioe = 6'b001111, e_we = 6'b111001, e_done = 6'b010000, e_cs = 6'b110000, e_busy = 6'b011111;
    b1.req = 1; b1.wr = 1; b1.addr = 15'h7FFF; b1.wdata = 8'h3C;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      b1.req = 0;
      checks++;
      if (b1.io_oe !== e_ioe[c] || b1.we !== e_we[c] || b1.cs !== e_cs[c] || b1.oe !== 1'b1) begin
        errors++; $display("FAIL write_pins c%0d got io_oe=%b we=%b cs=%b oe=%b want %b %b %b 1", c, b1.io_oe, b1.we, b1.cs, b1.oe, e_ioe[c], e_we[c], e_cs[c]);
      end
      checks++;
      if (b1.done !== e_done[c] || b1.busy !== e_busy[c] || b1.a !== 15'h7FFF || b1.io_out !== 8'h3C) begin
        errors++; $display("FAIL write_status c%0d got done=%b busy=%b a=%h io_out=%h want %b %b 7fff 3c", c, b1.done, b1.busy, b1.a, b1.io_out, e_done[c], e_busy[c]);
      end
    end
  endtask

  // Read then write with REQ held: read OE window c1-c2, RD_DONE c3,
  // TURN c4, IDLE c5, write setup c6 .. write done c10.
  task automatic test_back_to_back();
    logic [11:1] e_ioe = 11'b00111100000, e_done = 11'b01000000100, e_oe = 11'b11111111100;
    b1.req = 1; b1.wr = 0; b1.addr = 15'h00AA; b1.io_in = 8'h77;
    for (int c = 1; c <= 11; c++) begin
      cyc();
      if (c == 1) begin b1.wr = 1; b1.addr = 15'h0155; b1.wdata = 8'h55; end
      if (c == 6) b1.req = 0;
      checks++;
      if (b1.io_oe !== e_ioe[c] || b1.done !== e_done[c] || b1.oe !== e_oe[c]) begin
        errors++; $display("FAIL b2b c%0d got io_oe=%b done=%b oe=%b want %b %b %b", c, b1.io_oe, b1.done, b1.oe, e_ioe[c], e_done[c], e_oe[c]);
      end
      if (c == 3 || c == 6) begin
        checks++;
        if ((c == 3 && b1.rdata !== 8'h77) || (c == 6 && (b1.a !== 15'h0155 || b1.io_out !== 8'h55))) begin
          errors++; $display("FAIL b2b_data c%0d got rdata=%h a=%h io_out=%h", c, b1.rdata, b1.a, b1.io_out);
        end
      end
    end
    checks++;
    if (inv_viol !== 0) begin errors++; $display("FAIL invariants got %0d violations want 0", inv_viol); end
  endtask

  task automatic test_ignore();
    int dones = 0;
    b1.req = 1; b1.wr = 0; b1.addr = 15'h0100; b1.io_in = 8'h33;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      if (c == 1) begin b1.req = 1; b1.wr = 1; b1.addr = 15'h0200; end
      else b1.req = 0;
      if (b1.done === 1'b1) dones++;
      if (c <= 2) begin
        checks++;
        if (b1.a !== 15'h0100 || b1.cs !== 1'b0) begin
          errors++; $display("FAIL ignore_addr c%0d got a=%h cs=%b want 0100 0", c, b1.a, b1.cs);
        end
      end
    end
    checks++;
    if (dones != 1 || b1.busy !== 1'b0 || b1.rdata !== 8'h33) begin
      errors++; $display("FAIL ignore_done got dones=%0d busy=%b rdata=%h want 1 0 33", dones, b1.busy, b1.rdata);
    end
  endtask

  task automatic test_reset_abort();
    // write aborted in its first WE-low cycle
    b1.req = 1; b1.wr = 1; b1.addr = 15'h0ABC; b1.wdata = 8'h99;
    cyc(); b1.req = 0;
    cyc();
    checks++;
    if (b1.we !== 1'b0) begin errors++; $display("FAIL abort_wr_pulse got we=%b want 0", b1.we); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if ({b1.cs, b1.we, b1.io_oe, b1.busy, b1.done} !== 5'b11000) begin
      errors++; $display("FAIL abort_wr got cs,we,io_oe,busy,done=%b want 11000", {b1.cs, b1.we, b1.io_oe, b1.busy, b1.done});
    end
    for (int c = 0; c < 4; c++) begin
      cyc();
      checks++;
      if (b1.done !== 1'b0 || b1.busy !== 1'b0) begin errors++; $display("FAIL abort_wr_idle got done=%b busy=%b want 0 0", b1.done, b1.busy); end
    end
    // read aborted mid-window: no DONE, RDATA stays at its reset value
    b1.req = 1; b1.wr = 0; b1.addr = 15'h0044; b1.io_in = 8'h5A;
    cyc(); b1.req = 0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (b1.done !== 1'b0 || b1.rdata !== 8'h00 || b1.cs !== 1'b1) begin
        errors++; $display("FAIL abort_rd c%0d got done=%b rdata=%h cs=%b want 0 00 1", c, b1.done, b1.rdata, b1.cs);
      end
      cyc();
    end
  endtask

  task automatic test_random_stream();
    logic        w;
    logic [14:0] ad;
    logic [7:0]  d;
    int          t;
    for (int n = 0; n < 1000; n++) begin
      w  = 1'($urandom_range(0, 1));
      ad = (n % 4 == 0) ? 15'($urandom) : 15'($urandom_range(0, 31));
      d  = 8'($urandom);
      b2.req = 1; b2.wr = w; b2.addr = ad; b2.wdata = d;
      cyc();
      b2.req = 0;
      t = 0;
      while (t < 20 && b2.done !== 1'b1) begin cyc(); t++; end
      checks++;
      if (b2.done !== 1'b1) begin
        errors++; $display("FAIL rand_done n%0d got no done want done within 20 cycles", n);
      end else if (!w && ref_vld[ad]) begin
        checks++;
        if (b2.rdata !== ref_mem[ad]) begin
          errors++; $display("FAIL rand_read n%0d addr=%h got %h want %h", n, ad, b2.rdata, ref_mem[ad]);
        end
      end
      if (w) begin ref_mem[ad] = d; ref_vld[ad] = 1'b1; end
      t = 0;
      while (t < 10 && b2.busy !== 1'b0) begin cyc(); t++; end
    end
  endtask

  initial begin
    rst = 1'b1;
    cyc();
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_ignore();
    test_reset_abort();
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_sram_ctrl.md
MOD_SRAM_CTRL -- requirements
Module: mod_sram_ctrl

Interface
REQ-001 Parameter RD_CYC, default 2, meaning: clock cycles CS/OE are held low before read data is sampled (legal range 1-15).
REQ-002 Parameter WR_CYC, default 2, meaning: clock cycles WE is held low per write (legal range 1-15).
REQ-003 Parameter TURN_CYC, default 1, meaning: bus-turnaround cycles after a read before the next access may start (legal range 0-7).
REQ-004 CLK  input  1  system clock; all state changes on rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 REQ  input  1  host access request; sampled only while BUSY=0.
REQ-007 WR  input  1  access type; 1=write, 0=read; sampled with REQ.
REQ-008 ADDR  input  15  host address; sampled with REQ.
REQ-009 WDATA  input  8  host write data; sampled with REQ.
REQ-010 RDATA  output  8  read data; held until the next read completes.
REQ-011 BUSY  output  1  high whenever the state is not IDLE.
REQ-012 DONE  output  1  one-cycle completion pulse for every accepted access.
REQ-013 A  output  15  SRAM address.
REQ-014 CS  output  1  SRAM chip select, active low.
REQ-015 OE  output  1  SRAM output enable, active low.
REQ-016 WE  output  1  SRAM write enable, active low.
REQ-017 IO_OUT  output  8  data driven toward the SRAM IO bus.
REQ-018 IO_OE  output  1  1 = IO_OUT drives the IO bus; 0 = bus released (tristate buffer is outside this block).
REQ-019 IO_IN  input  8  IO bus value as seen from the SRAM side.

Function
REQ-020 States SHALL be IDLE, RD_ACT, RD_DONE, TURN, WR_SETUP, WR_PULSE, WR_HOLD, WR_DONE; all outputs registered.
REQ-021 Accept: in IDLE, REQ=1 at edge k latches ADDR, WR, and WDATA, and moves to RD_ACT (WR=0) or WR_SETUP (WR=1); BUSY=1 from cycle k+1.
REQ-022 Read: cycles k+1..k+RD_CYC in RD_ACT with CS=0, OE=0, WE=1, IO_OE=0, A=latched ADDR; RDATA<=IO_IN on the edge ending the last RD_ACT cycle.
REQ-023 Read completion: cycle k+RD_CYC+1 in RD_DONE with CS=1, OE=1, DONE=1; then TURN for TURN_CYC cycles (skipped when 0); then IDLE.
REQ-024 Write: cycle k+1 in WR_SETUP with CS=0, OE=1, WE=1, IO_OE=1, IO_OUT=latched WDATA.
REQ-025 Write pulse: cycles k+2..k+1+WR_CYC in WR_PULSE with WE=0; CS, OE, and data unchanged.
REQ-026 Write hold: cycle k+2+WR_CYC in WR_HOLD with WE=1, CS=0, and IO_OE=1 with data still driven.
REQ-027 Write completion: cycle k+3+WR_CYC in WR_DONE with CS=1, IO_OE=0, DONE=1; then IDLE.
REQ-028 Total latency from accept edge to DONE: read RD_CYC+1 cycles; write WR_CYC+3 cycles.
REQ-029 REQ while BUSY=1 SHALL be ignored, not queued; the host must re-present REQ after BUSY falls.
REQ-030 REQ held high in IDLE SHALL be accepted immediately, giving back-to-back accesses separated only by TURN/WR_DONE.
REQ-031 Invariant: WE=0 and OE=0 never occur in the same cycle.
REQ-032 Invariant: IO_OE=1 never occurs while OE=0, nor in RD_DONE or TURN.
REQ-033 Invariant: A and IO_OUT never change while CS=0.
REQ-034 Invariant: WE falls only while CS=0 and rises at least one cycle before CS rises.
REQ-035 A SHALL retain the last address in IDLE; cycle counters SHALL be 4 bits and reload on every state entry, with no wrap-around.

Reset
REQ-036 While RST=1, the state SHALL go to IDLE.
REQ-037 While RST=1: CS=1, OE=1, WE=1, IO_OE=0, BUSY=0, DONE=0, RDATA=8'h00, A=15'h0000, IO_OUT=8'h00, counters=0.
REQ-038 RST asserted mid-access SHALL abort the access on the next edge; no DONE, and RDATA keeps its reset value.
REQ-039 A write aborted by RST SHALL release WE to 1 at the same edge as CS.

Verification
REQ-040 Defaults, read: REQ=1, WR=0, ADDR=15'h1234, IO_IN=8'hA5 -> CS=OE=0 for 2 cycles; DONE in cycle k+3; RDATA=8'hA5; BUSY low at k+5.
REQ-041 Write: REQ=1, WR=1, ADDR=15'h7FFF, WDATA=8'h3C -> IO_OE=1 in cycles k+1..k+4; WE=0 in k+2..k+3 only; DONE at k+5; OE stays 1.
REQ-042 Write-after-read with REQ held high and TURN_CYC=1 -> IO_OE stays 0 until 2 cycles after the read's final OE=0 cycle; invariant checkers REQ-031..034 pass.
REQ-043 REQ pulsed during an active read -> ignored; exactly one DONE; A unchanged while CS=0.
REQ-044 RST=1 in the first WR_PULSE cycle -> next cycle CS=WE=1, IO_OE=0, BUSY=0, no DONE.
REQ-045 Parameters RD_CYC=1, WR_CYC=1, TURN_CYC=0, random 1000-access stream checked against a 32K x 8 reference array -> all reads match the last written data.
